// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path (main FSM and ALU control).
package mips_pkg;

    localparam int unsigned OPW = 6;
    localparam int unsigned STW = 4;

    // Opcodes (instr[31:26])
    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;

    // aluOp encodings consumed by the ALU control decoder
    localparam logic [1:0] ALUOP_RTYPE = 2'b00;
    localparam logic [1:0] ALUOP_ADD   = 2'b01;
    localparam logic [1:0] ALUOP_BEQ   = 2'b10;
    localparam logic [1:0] ALUOP_BNE   = 2'b11;

    // ALU B operand select
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [STW-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // Datapath control bundle produced per state
    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       illegal_op;
    } ctrl_t;

    // True for the opcodes this controller sequences
    function automatic logic is_legal_op(input logic [OPW-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_BNE) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_main_ctrl_decode.sv
// Moore output map: current state (plus opReg/opcode/memReady qualifiers) to datapath controls.
module mc_ctrl_decode
    import mips_pkg::*;
(
    input  state_t         st,
    input  logic [OPW-1:0] op_reg,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output ctrl_t          ctrl
);

    // Per-state control values; everything not listed for a state stays 0
    always_comb begin
        ctrl = '0;
        case (st)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_IMMSH;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.illegal_op = ~is_legal_op(opcode);
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REGB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PCSRC_ALUOUT;
                ctrl.alu_op        = (op_reg == OP_BNE) ? ALUOP_BNE : ALUOP_BEQ;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
            default: begin
                ctrl.illegal_op = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM: state/opReg registers, next-state logic, reset gating of outputs.
module mc_main_ctrl
    import mips_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           memReady,
    output logic [1:0]     aluOp,
    output logic           aluSrcA,
    output logic [1:0]     aluSrcB,
    output logic [1:0]     pcSrc,
    output logic           pcWrite,
    output logic           pcWriteCond,
    output logic           iorD,
    output logic           memRead,
    output logic           memWrite,
    output logic           irWrite,
    output logic           regDst,
    output logic           memToReg,
    output logic           regWrite,
    output logic           illegalOp,
    output logic [STW-1:0] state
);

    state_t         state_q;
    state_t         state_nxt;
    logic [OPW-1:0] op_reg;
    ctrl_t          ctrl;
    ctrl_t          ctrl_out;

    // State register; opcode is captured in DECODE so later states ignore IR changes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_reg  <= '0;
        end else begin
            state_q <= state_nxt;
            if (state_q == S_DECODE) begin
                op_reg <= opcode;
            end
        end
    end

    // Next-state sequencing; memory states hold until memReady
    always_comb begin
        state_nxt = S_FETCH;
        case (state_q)
            S_FETCH:  state_nxt = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_nxt = S_EXEC;
                    OP_LW, OP_SW:  state_nxt = S_MEMADR;
                    OP_BEQ,OP_BNE: state_nxt = S_BRANCH;
                    OP_ADDI:       state_nxt = S_ADDIEX;
                    OP_J:          state_nxt = S_JUMP;
                    default:       state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: state_nxt = (op_reg == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_nxt = memReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_nxt = memReady ? S_FETCH : S_MEMWR;
            S_EXEC:   state_nxt = S_ALUWB;
            S_ADDIEX: state_nxt = S_ADDIWB;
            default:  state_nxt = S_FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .st        (state_q),
        .op_reg    (op_reg),
        .opcode    (opcode),
        .mem_ready (memReady),
        .ctrl      (ctrl)
    );

    // All outputs, including memory requests, are forced low while reset is asserted
    always_comb begin
        ctrl_out = rst ? '0 : ctrl;
    end

    assign aluOp       = ctrl_out.alu_op;
    assign aluSrcA     = ctrl_out.alu_src_a;
    assign aluSrcB     = ctrl_out.alu_src_b;
    assign pcSrc       = ctrl_out.pc_src;
    assign pcWrite     = ctrl_out.pc_write;
    assign pcWriteCond = ctrl_out.pc_write_cond;
    assign iorD        = ctrl_out.ior_d;
    assign memRead     = ctrl_out.mem_read;
    assign memWrite    = ctrl_out.mem_write;
    assign irWrite     = ctrl_out.ir_write;
    assign regDst      = ctrl_out.reg_dst;
    assign memToReg    = ctrl_out.mem_to_reg;
    assign regWrite    = ctrl_out.reg_write;
    assign illegalOp   = ctrl_out.illegal_op;
    assign state       = rst ? '0 : STW'(state_q);

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Bench for mc_main_ctrl: directed vector table followed by randomized instruction stream vs. reference model.
module tb_mc_main_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       memReady;
    logic [1:0] aluOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       regDst, memToReg, regWrite, illegalOp;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    mc_main_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .memReady(memReady),
        .aluOp(aluOp), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSrc(pcSrc),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite),
        .illegalOp(illegalOp), .state(state)
    );

    always #5 clk = ~clk;

    // Observed vector: {aluOp, aluSrcA, aluSrcB, pcSrc, enables[9:0], state}
    // enables = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, illegalOp}
    logic [20:0] got;
    assign got = {aluOp, aluSrcA, aluSrcB, pcSrc, pcWrite, pcWriteCond, iorD, memRead, memWrite,
                  irWrite, regDst, memToReg, regWrite, illegalOp, state};

    function automatic logic [20:0] pk(input int st, input logic [1:0] aop, input logic sa,
                                       input logic [1:0] sb, input logic [1:0] ps, input logic [9:0] en);
        return {aop, sa, sb, ps, en, 4'(st)};
    endfunction

    task automatic check(input string name, input logic [20:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (state got %0d req %0d)", name, got, exp, state, exp[3:0]);
        end
    endtask

    // Reference: outputs for a given state of an instruction, taken from the state table
    function automatic logic [20:0] ref_out(input int p, input logic [5:0] iop, input logic rdy);
        logic legal;
        legal = (iop == 6'b000000) || (iop == 6'b100011) || (iop == 6'b101011) || (iop == 6'b000100) ||
                (iop == 6'b000101) || (iop == 6'b001000) || (iop == 6'b000010);
        case (p)
            0:  return pk(0, 2'b01, 1'b0, 2'b01, 2'b00, {rdy, 2'b00, 1'b1, 1'b0, rdy, 4'b0000});
            1:  return pk(1, 2'b01, 1'b0, 2'b11, 2'b00, {9'b0, ~legal});
            2:  return pk(2, 2'b01, 1'b1, 2'b10, 2'b00, 10'b0);
            3:  return pk(3, 2'b00, 1'b0, 2'b00, 2'b00, 10'b0011000000);
            4:  return pk(4, 2'b00, 1'b0, 2'b00, 2'b00, 10'b0000000110);
            5:  return pk(5, 2'b00, 1'b0, 2'b00, 2'b00, 10'b0010100000);
            6:  return pk(6, 2'b00, 1'b1, 2'b00, 2'b00, 10'b0);
            7:  return pk(7, 2'b00, 1'b0, 2'b00, 2'b00, 10'b0000001010);
            8:  return pk(8, (iop == 6'b000101) ? 2'b11 : 2'b10, 1'b1, 2'b00, 2'b01, 10'b0100000000);
            9:  return pk(9, 2'b01, 1'b1, 2'b10, 2'b00, 10'b0);
            10: return pk(10, 2'b00, 1'b0, 2'b00, 2'b00, 10'b0000000010);
            default: return pk(11, 2'b00, 1'b0, 2'b00, 2'b10, 10'b1000000000);
        endcase
    endfunction

    typedef struct {
        logic        r;
        logic [5:0]  op;
        logic        rdy;
        logic [20:0] exp;
        string       name;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic r, input logic [5:0] op, input logic rdy,
                                input logic [20:0] exp, input string name);
        vec_t v;
        v.r = r; v.op = op; v.rdy = rdy; v.exp = exp; v.name = name;
        return v;
    endfunction

    initial begin
        logic [20:0] f_go, f_stall, dec_ok, zero;
        int          phases[$];
        logic [5:0]  iop;
        int          idx;
        int          stalls;
        bit          aborted;

        f_go    = pk(0, 2'b01, 1'b0, 2'b01, 2'b00, 10'b1001010000);
        f_stall = pk(0, 2'b01, 1'b0, 2'b01, 2'b00, 10'b0001000000);
        dec_ok  = pk(1, 2'b01, 1'b0, 2'b11, 2'b00, 10'b0);
        zero    = '0;

        // Reset held two cycles
        tv.push_back(mk(1, 6'h00, 1, zero, "reset0"));
        tv.push_back(mk(1, 6'h00, 1, zero, "reset1"));
        // R-type
        tv.push_back(mk(0, 6'b000000, 1, f_go, "r_fetch"));
        tv.push_back(mk(0, 6'b000000, 1, dec_ok, "r_decode"));
        tv.push_back(mk(0, 6'b000000, 1, pk(6, 2'b00, 1'b1, 2'b00, 2'b00, 10'b0), "r_exec"));
        tv.push_back(mk(0, 6'b000000, 1, pk(7, 2'b00, 1'b0, 2'b00, 2'b00, 10'b0000001010), "r_aluwb"));
        // lw with a fetch stall, opcode changed after decode, two MEMRD stalls
        tv.push_back(mk(0, 6'b100011, 0, f_stall, "lw_fetch_stall"));
        tv.push_back(mk(0, 6'b100011, 1, f_go, "lw_fetch"));
        tv.push_back(mk(0, 6'b100011, 0, dec_ok, "lw_decode"));
        tv.push_back(mk(0, 6'b000000, 0, pk(2, 2'b01, 1'b1, 2'b10, 2'b00, 10'b0), "lw_memadr"));
        tv.push_back(mk(0, 6'b000000, 0, pk(3, 2'b00, 1'b0, 2'b00, 2'b00, 10'b0011000000), "lw_memrd0"));
        tv.push_back(mk(0, 6'b000000, 0, pk(3, 2'b00, 1'b0, 2'b00, 2'b00, 10'b0011000000), "lw_memrd1"));
        tv.push_back(mk(0, 6'b000000, 1, pk(3, 2'b00, 1'b0, 2'b00, 2'b00, 10'b0011000000), "lw_memrd2"));
        tv.push_back(mk(0, 6'b000000, 1, pk(4, 2'b00, 1'b0, 2'b00, 2'b00, 10'b0000000110), "lw_memwb"));
        // beq then bne
        tv.push_back(mk(0, 6'b000100, 1, f_go, "beq_fetch"));
        tv.push_back(mk(0, 6'b000100, 1, dec_ok, "beq_decode"));
        tv.push_back(mk(0, 6'b000101, 1, pk(8, 2'b10, 1'b1, 2'b00, 2'b01, 10'b0100000000), "beq_branch"));
        tv.push_back(mk(0, 6'b000101, 1, f_go, "bne_fetch"));
        tv.push_back(mk(0, 6'b000101, 1, dec_ok, "bne_decode"));
        tv.push_back(mk(0, 6'b000100, 1, pk(8, 2'b11, 1'b1, 2'b00, 2'b01, 10'b0100000000), "bne_branch"));
        // Illegal opcode: single-cycle illegalOp, back to FETCH
        tv.push_back(mk(0, 6'b111111, 1, f_go, "ill_fetch"));
        tv.push_back(mk(0, 6'b111111, 1, pk(1, 2'b01, 1'b0, 2'b11, 2'b00, 10'b0000000001), "ill_decode"));
        tv.push_back(mk(0, 6'b111111, 0, f_stall, "ill_back_fetch"));
        // sw stalled in MEMWR, then reset for one cycle
        tv.push_back(mk(0, 6'b101011, 1, f_go, "sw_fetch"));
        tv.push_back(mk(0, 6'b101011, 1, dec_ok, "sw_decode"));
        tv.push_back(mk(0, 6'b101011, 0, pk(2, 2'b01, 1'b1, 2'b10, 2'b00, 10'b0), "sw_memadr"));
        tv.push_back(mk(0, 6'b101011, 0, pk(5, 2'b00, 1'b0, 2'b00, 2'b00, 10'b0010100000), "sw_memwr"));
        tv.push_back(mk(1, 6'b101011, 0, zero, "sw_reset"));
        tv.push_back(mk(0, 6'b000010, 1, f_go, "after_rst_fetch"));
        // Jump
        tv.push_back(mk(0, 6'b000010, 1, dec_ok, "j_decode"));
        tv.push_back(mk(0, 6'b000010, 1, pk(11, 2'b00, 1'b0, 2'b00, 2'b10, 10'b1000000000), "j_jump"));
        tv.push_back(mk(0, 6'b000010, 0, f_stall, "j_back_fetch"));

        rst = 1'b1; opcode = '0; memReady = 1'b0;

        foreach (tv[i]) begin
            @(negedge clk);
            rst = tv[i].r; opcode = tv[i].op; memReady = tv[i].rdy;
            #1 check(tv[i].name, tv[i].exp);
        end

        // Randomized instruction stream; DUT is in FETCH here
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 7))
                0: iop = 6'b000000;
                1: iop = 6'b100011;
                2: iop = 6'b101011;
                3: iop = 6'b000100;
                4: iop = 6'b000101;
                5: iop = 6'b001000;
                6: iop = 6'b000010;
                default: iop = 6'($urandom);
            endcase
            phases = '{0, 1};
            case (iop)
                6'b000000:            phases = '{0, 1, 6, 7};
                6'b100011:            phases = '{0, 1, 2, 3, 4};
                6'b101011:            phases = '{0, 1, 2, 5};
                6'b000100, 6'b000101: phases = '{0, 1, 8};
                6'b001000:            phases = '{0, 1, 9, 10};
                6'b000010:            phases = '{0, 1, 11};
                default:              phases = '{0, 1};
            endcase
            idx = 0; stalls = 0; aborted = 0;
            while (idx < phases.size() && !aborted) begin
                @(negedge clk);
                rst      = ($urandom_range(0, 99) < 2);
                memReady = (stalls >= 4) ? 1'b1 : ($urandom_range(0, 3) != 0);
                opcode   = (phases[idx] <= 1) ? iop : 6'($urandom);
                #1;
                if (rst) begin
                    check("rand_reset", zero);
                    aborted = 1;
                end else begin
                    check($sformatf("rand_op%b_st%0d", iop, phases[idx]), ref_out(phases[idx], iop, memReady));
                    if ((phases[idx] == 0 || phases[idx] == 3 || phases[idx] == 5) && !memReady) begin
                        stalls++;
                    end else begin
                        idx++;
                        stalls = 0;
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
